// File: rtl/alu8_operand_sequencer.sv
// Operand/opcode loader for the 8-bit 74181/74182 ALU: steps A, B, opcode from switches,
// holds operands for a settle window, then captures result, carry and zero for display.
module alu8_operand_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btn_load,
    input  logic       btn_clear,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    output logic       alu_mode,
    output logic       alu_cin,
    input  logic [7:0] alu_result,
    input  logic       alu_cout,
    output logic [7:0] res,
    output logic       res_cout,
    output logic       res_zero,
    output logic       res_valid,
    output logic [2:0] state
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_SHOW = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             btn_load_q;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [3:0]       sel_q, sel_d;
    logic             mode_q, mode_d;
    logic             cin_q, cin_d;
    logic [7:0]       res_q, res_d;
    logic             res_cout_q, res_cout_d;
    logic             res_zero_q, res_zero_d;
    logic             res_valid_q, res_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_ev;

    assign load_ev = btn_load & ~btn_load_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        mode_d      = mode_q;
        cin_d       = cin_q;
        res_d       = res_q;
        res_cout_d  = res_cout_q;
        res_zero_d  = res_zero_q;
        res_valid_d = res_valid_q;
        cnt_d       = cnt_q;

        if (btn_clear) begin
            state_d     = S_A;
            a_d         = '0;
            b_d         = '0;
            sel_d       = '0;
            mode_d      = 1'b0;
            cin_d       = 1'b0;
            res_d       = '0;
            res_cout_d  = 1'b0;
            res_zero_d  = 1'b0;
            res_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                S_A: if (load_ev) begin
                    a_d     = sw;
                    state_d = S_B;
                end
                S_B: if (load_ev) begin
                    b_d     = sw;
                    state_d = S_OP;
                end
                S_OP: if (load_ev) begin
                    sel_d       = sw[3:0];
                    mode_d      = sw[4];
                    cin_d       = sw[5];
                    res_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_EXEC;
                end
                S_EXEC: begin
                    // cnt tops out at SETTLE_CYCLES, which CNT_W always holds
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        res_d       = alu_result;
                        res_cout_d  = alu_cout;
                        res_zero_d  = (alu_result == 8'h00);
                        res_valid_d = 1'b1;
                        state_d     = S_SHOW;
                    end
                end
                S_SHOW: if (load_ev) state_d = S_A;
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_A;
            btn_load_q  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            res_q       <= '0;
            res_cout_q  <= 1'b0;
            res_zero_q  <= 1'b0;
            res_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            btn_load_q  <= btn_load;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            mode_q      <= mode_d;
            cin_q       <= cin_d;
            res_q       <= res_d;
            res_cout_q  <= res_cout_d;
            res_zero_q  <= res_zero_d;
            res_valid_q <= res_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;
    assign alu_mode  = mode_q;
    assign alu_cin   = cin_q;
    assign res       = res_q;
    assign res_cout  = res_cout_q;
    assign res_zero  = res_zero_q;
    assign res_valid = res_valid_q;
    assign state     = state_q;

endmodule
